tug_round_judge: RTL and testbench

Producer side of the score counter interface. It runs one tug-of-war round on an LED bar: it edge-detects the two players' keys, moves a single lit LED toward the pressing player, and emits a one-cycle point pulse tagged with the winner when the light is pushed off an end. The downstream per-player score counters increment only on that pulse. This block then holds the final position briefly, re-centres the light, and stops on a game-over input.

---
 rtl/tug_round_judge.sv | 132 +++++++++++++
 tb/tb_tug_round_judge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_round_judge.sv
// Tug-of-war round judge: moves a one-hot light toward the pressing player and
// issues a one-cycle point pulse, tagged with the winner, when the light leaves an end.
module tug_round_judge #(
    parameter int N_LED       = 9,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             L,
    input  logic             R,
    input  logic             game_over,
    output logic [N_LED-1:0] led,
    output logic             point,
    output logic             winner,
    output logic             busy
);

    localparam int POS_W = $clog2(N_LED);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] CENTRE    = POS_W'((N_LED - 1) / 2);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_LED-1:0] LED_ONE   = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        PLAY,
        HOLD,
        OVER
    } state_t;

    state_t           state, state_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Two-stage key history; the pair resets to "held" so a key down through
    // reset must be released before it can register a press.
    logic l_s, l_q, r_s, r_q;
    logic press_l, press_r;
    logic move_l, move_r;
    logic win_l, win_r;

    logic             point_nxt, winner_nxt, busy_nxt;
    logic [N_LED-1:0] led_nxt;

    assign press_l = l_s & ~l_q;
    assign press_r = r_s & ~r_q;

    assign move_l = (state == PLAY) & ~game_over & press_l & ~press_r;
    assign move_r = (state == PLAY) & ~game_over & press_r & ~press_l;
    assign win_l  = move_l & (pos == POS_MAX);
    assign win_r  = move_r & (pos == '0);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= PLAY;
            pos   <= CENTRE;
            cnt   <= '0;
            l_s   <= 1'b1;
            l_q   <= 1'b1;
            r_s   <= 1'b1;
            r_q   <= 1'b1;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            cnt   <= cnt_nxt;
            l_s   <= L;
            l_q   <= l_s;
            r_s   <= R;
            r_q   <= r_s;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        cnt_nxt   = cnt;
        case (state)
            PLAY: begin
                if (game_over) begin
                    state_nxt = OVER;
                end else if (win_l || win_r) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else if (move_l) begin
                    pos_nxt = pos + 1'b1;
                end else if (move_r) begin
                    pos_nxt = pos - 1'b1;
                end
            end
            HOLD: begin
                if (game_over) begin
                    state_nxt = OVER;
                end else if (cnt == '0) begin
                    state_nxt = PLAY;
                    pos_nxt   = CENTRE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next values of the registered outputs; winner keeps its last value when
    // no point is issued since it is only meaningful alongside point.
    always_comb begin
        point_nxt  = win_l | win_r;
        winner_nxt = (win_l | win_r) ? win_l : winner;
        busy_nxt   = (state_nxt != PLAY);
        led_nxt    = LED_ONE << pos_nxt;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            led    <= LED_ONE << CENTRE;
            point  <= 1'b0;
            winner <= 1'b0;
            busy   <= 1'b0;
        end else begin
            led    <= led_nxt;
            point  <= point_nxt;
            winner <= winner_nxt;
            busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_tug_round_judge.sv
// Bench for tug_round_judge: directed round scenarios plus random key traffic,
// scored cycle by cycle against a round-level reference model.
module tb_tug_round_judge;

    localparam int N_LED       = 9;
    localparam int HOLD_CYCLES = 4;
    localparam int C           = (N_LED - 1) / 2;

    localparam logic [N_LED-1:0] LED_CENTRE = 9'b000010000;
    localparam logic [N_LED-1:0] LED_LEFT   = 9'b100000000;
    localparam logic [N_LED-1:0] LED_BIT5   = 9'b000100000;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             L;
    logic             R;
    logic             game_over;
    logic [N_LED-1:0] led;
    logic             point;
    logic             winner;
    logic             busy;

    always #5 Clock = ~Clock;

    tug_round_judge #(
        .N_LED      (N_LED),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .L        (L),
        .R        (R),
        .game_over(game_over),
        .led      (led),
        .point    (point),
        .winner   (winner),
        .busy     (busy)
    );

    typedef struct {
        logic [N_LED-1:0] led;
        logic             point;
        logic             winner;
        logic             busy;
        bit               chk_win;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: light position, round phase, cycles of hold left,
    // and the two most recent key samples the judge has seen.
    typedef enum int { M_PLAY, M_HOLD, M_OVER } mode_t;
    int    m_pos;
    mode_t m_mode;
    int    m_hold_left;
    bit    m_l_now, m_l_prev, m_r_now, m_r_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit l, input bit r, input bit go, input bit rst, output exp_t e);
        bit pl, pr;
        e.point  = 1'b0;
        e.winner = 1'b0;
        if (rst) begin
            m_pos       = C;
            m_mode      = M_PLAY;
            m_hold_left = 0;
            m_l_now     = 1'b1;
            m_l_prev    = 1'b1;
            m_r_now     = 1'b1;
            m_r_prev    = 1'b1;
        end else begin
            pl = m_l_now && !m_l_prev;
            pr = m_r_now && !m_r_prev;
            if (m_mode == M_PLAY) begin
                if (go) m_mode = M_OVER;
                else if (pl && !pr) begin
                    if (m_pos == N_LED - 1) begin
                        e.point = 1'b1; e.winner = 1'b1;
                        m_mode = M_HOLD; m_hold_left = HOLD_CYCLES;
                    end else m_pos = m_pos + 1;
                end else if (pr && !pl) begin
                    if (m_pos == 0) begin
                        e.point = 1'b1; e.winner = 1'b0;
                        m_mode = M_HOLD; m_hold_left = HOLD_CYCLES;
                    end else m_pos = m_pos - 1;
                end
            end else if (m_mode == M_HOLD) begin
                if (go) m_mode = M_OVER;
                else begin
                    m_hold_left = m_hold_left - 1;
                    if (m_hold_left == 0) begin
                        m_mode = M_PLAY;
                        m_pos  = C;
                    end
                end
            end
            m_l_prev = m_l_now; m_l_now = l;
            m_r_prev = m_r_now; m_r_now = r;
        end
        e.led        = '0;
        e.led[m_pos] = 1'b1;
        e.busy       = (m_mode != M_PLAY);
        e.chk_win    = e.point || rst;
    endtask

    // Drive one clock's worth of inputs, log the model's expectation, and
    // return at the following negedge.
    task automatic step(input bit l, input bit r, input bit go, input bit rst);
        exp_t e;
        L = l; R = r; game_over = go; Reset = rst;
        model_edge(l, r, go, rst, e);
        sb.push_back(e);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tap_l();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tap_r();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (led !== e.led || point !== e.point || busy !== e.busy ||
                (e.chk_win && winner !== e.winner)) begin
                n_err++;
                $display("FAIL cycle_out @%0t: got led=%b point=%b winner=%b busy=%b, expected led=%b point=%b winner=%b busy=%b",
                         $time, led, point, winner, busy, e.led, e.point, e.winner, e.busy);
            end
        end
    end

    initial begin
        int bias_l, bias_r, drain;

        // Reset with L held, then a clean press moves one step left.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_led", 32'(led), 32'(LED_CENTRE));
        check("reset_point", 32'(point), 0);
        check("reset_busy", 32'(busy), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_through_reset", 32'(led), 32'(LED_CENTRE));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tap_l();
        check("first_press_led", 32'(led), 32'(LED_BIT5));
        tap_r();

        // Left win and hold timing.
        repeat (4) tap_l();
        check("left_end_led", 32'(led), 32'(LED_LEFT));
        tap_l();
        check("left_win_point", 32'(point), 1);
        check("left_win_winner", 32'(winner), 1);
        check("left_win_busy", 32'(busy), 1);
        for (int i = 0; i < HOLD_CYCLES - 1; i++) begin
            idle(1);
            check("hold_led", 32'(led), 32'(LED_LEFT));
            check("hold_busy", 32'(busy), 1);
        end
        idle(1);
        check("recentre_led", 32'(led), 32'(LED_CENTRE));
        check("recentre_busy", 32'(busy), 0);

        // Simultaneous presses cancel.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("both_keys_led", 32'(led), 32'(LED_CENTRE));

        // Right win, presses ignored during hold.
        repeat (5) tap_r();
        check("right_win_point", 32'(point), 1);
        check("right_win_winner", 32'(winner), 0);
        tap_l();
        tap_l();
        check("hold_ignores_press", 32'(led), 32'(LED_CENTRE));
        tap_l();
        check("after_hold_press", 32'(led), 32'(LED_BIT5));
        tap_r();

        // game_over during hold freezes at the end LED until reset.
        repeat (5) tap_l();
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tap_r();
        tap_l();
        check("over_led", 32'(led), 32'(LED_LEFT));
        check("over_busy", 32'(busy), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("over_reset_led", 32'(led), 32'(LED_CENTRE));
        check("over_reset_busy", 32'(busy), 0);
        idle(1);

        // A key held for 20 cycles moves once.
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("long_hold_led", 32'(led), 32'(LED_BIT5));
        tap_r();

        // Reset in the middle of a hold.
        repeat (5) tap_r();
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_hold_reset_led", 32'(led), 32'(LED_CENTRE));
        check("mid_hold_reset_point", 32'(point), 0);
        check("mid_hold_reset_busy", 32'(busy), 0);

        // Random traffic with per-block press bias so rounds actually get won.
        for (int blk = 0; blk < 40; blk++) begin
            bias_l = $urandom_range(10, 70);
            bias_r = $urandom_range(10, 70);
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < bias_l,
                     $urandom_range(0, 99) < bias_r,
                     $urandom_range(0, 399) == 0,
                     $urandom_range(0, 249) == 0);
            end
        end

        idle(2);
        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge Clock);
            drain++;
        end
        if (sb.size() > 0) check("scoreboard_drain", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
